// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates two cache ports (0 = I-cache, 1 = D-cache) onto one
// shared main memory and sequences one block transaction at a time.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   req0/1, isRead0/1             request (held until ack) and direction (1 = read)
//   addr0/1, wdata0/1             request byte address and write block
//   ack0/1, err0/1                one-cycle completion pulse, timeout flag with ack
//   readData                      read block, valid in the ack cycle, held until next ack
//   memReq, isMemRead             memory transaction active and its direction
//   memAddr, memWriteData         block-aligned address and write block, stable while memReq
//   memReady, memReadData         one-cycle memory completion and read block
//
// Configuration: define MEM_ARB_FIXED_PRIO_EN for strict priority (port 0 always wins
// contention); otherwise round-robin alternates under contention.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               isRead0,
    input  logic               isRead1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [BLOCK_W-1:0] wdata0,
    input  logic [BLOCK_W-1:0] wdata1,
    output logic               ack0,
    output logic               ack1,
    output logic               err0,
    output logic               err1,
    output logic [BLOCK_W-1:0] readData,
    output logic               memReq,
    output logic               isMemRead,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [BLOCK_W-1:0] memWriteData,
    input  logic               memReady,
    input  logic [BLOCK_W-1:0] memReadData
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-4){1'b1}}, 4'b0};

    logic [1:0]         state;
    logic [7:0]         timer;
    logic               win;
    logic               last_grant;
    logic               aborted;
    logic               pick;
    logic [BLOCK_W-1:0] cap_data;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick = !req0;
`else
    // under contention the port that did not win last time goes next
    assign pick = (req0 && req1) ? !last_grant : req1;
`endif

    // the request fields are latched straight into the memory-side registers at
    // grant time, so later changes on the request inputs cannot leak through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= 8'd0;
            win          <= 1'b0;
            last_grant   <= 1'b1;
            aborted      <= 1'b0;
            cap_data     <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            readData     <= '0;
            memReq       <= 1'b0;
            isMemRead    <= 1'b1;
            memAddr      <= '0;
            memWriteData <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    win          <= pick;
                    isMemRead    <= pick ? isRead1 : isRead0;
                    memAddr      <= (pick ? addr1 : addr0) & ADDR_MASK;
                    memWriteData <= pick ? wdata1 : wdata0;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    memReq  <= 1'b1;
                    timer   <= 8'd0;
                    aborted <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: if (memReady) begin
                    if (isMemRead) cap_data <= memReadData;
                    state <= RESP;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    aborted <= 1'b1;
                    state   <= RESP;
                end else begin
                    timer <= timer + 8'd1;
                end
                default: begin
                    memReq     <= 1'b0;
                    ack0       <= !win;
                    ack1       <= win;
                    err0       <= !win && aborted;
                    err1       <= win && aborted;
                    if (isMemRead) readData <= aborted ? '0 : cap_data;
                    last_grant <= win;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus against a timeline model of the arbiter
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int BW = 128;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req0, req1, isRead0, isRead1, memReady;
    logic [AW-1:0] addr0, addr1, memAddr;
    logic [BW-1:0] wdata0, wdata1, memReadData, readData, memWriteData;
    logic ack0, ack1, err0, err1, memReq, isMemRead;

    logic r[2];
    logic rdf[2];
    logic [AW-1:0] ad[2];
    logic [BW-1:0] wd[2];
    assign req0 = r[0];
    assign req1 = r[1];
    assign isRead0 = rdf[0];
    assign isRead1 = rdf[1];
    assign addr0 = ad[0];
    assign addr1 = ad[1];
    assign wdata0 = wd[0];
    assign wdata1 = wd[1];

    mem_port_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .isRead0(isRead0), .isRead1(isRead1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .readData(readData),
        .memReq(memReq), .isMemRead(isMemRead), .memAddr(memAddr),
        .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    // Model: a transaction accepted at edge E with memory answering on its k-th wait
    // edge ends (RESP entered) at edge R = E+1+min(k,TO); memReq is visible after
    // edges E+1..R, the ack after edge R+1.
    int n = 0, E = 0, R = 0, w = 0, last = 1, force_k = -1;
    bit busy, ok, m_rd, force_data_en, auto_req;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wd, m_data, force_data;
    bit e_memreq, e_isread;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_wdata, e_rdata;
    bit e_ack[2], e_err[2];
    int compared = 0, mismatched = 0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam int EXP_ORDER[4] = '{0, 0, 0, 0};
`else
    localparam int EXP_ORDER[4] = '{0, 1, 0, 1};
`endif

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; last = 1; force_k = -1; force_data_en = 0;
        e_memreq = 0; e_isread = 1; e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_ack = '{0, 0}; e_err = '{0, 0};
    endtask

    function automatic int rand_k();
        case ($urandom_range(0, 9))
            0: return TO;
            1: return TO + 1;
            2: return TO - 1;
            default: return int'($urandom_range(1, 5));
        endcase
    endfunction

    task automatic model_step();
        int k;
        n++;
        e_ack = '{0, 0};
        e_err = '{0, 0};
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!busy) begin
            if (r[0] || r[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = r[0] ? 0 : 1;
`else
                w = (r[0] && r[1]) ? 1 - last : (r[1] ? 1 : 0);
`endif
                busy = 1; E = n;
                m_rd = rdf[w]; m_addr = ad[w]; m_wd = wd[w];
                k = (force_k >= 0) ? force_k : rand_k();
                force_k = -1;
                ok = (k <= TO);
                R = E + 1 + (ok ? k : TO);
                m_data = force_data_en ? force_data : {$urandom, $urandom, $urandom, $urandom};
                force_data_en = 0;
            end
        end else if (n == E + 1) begin
            e_memreq = 1; e_isread = m_rd; e_wdata = m_wd;
            e_addr = {m_addr[AW-1:4], 4'h0};
        end else if (n == R + 1) begin
            e_memreq = 0;
            e_ack[w] = 1;
            e_err[w] = !ok;
            if (m_rd) e_rdata = ok ? m_data : '0;
            last = w;
            busy = 0;
        end
    endtask

    task automatic compare();
        chk("memReq", memReq, e_memreq);
        chk("ack0", ack0, e_ack[0]);
        chk("ack1", ack1, e_ack[1]);
        chk("err0", err0, e_err[0]);
        chk("err1", err1, e_err[1]);
        chk("readData", readData, e_rdata);
        if (e_memreq) begin
            chk("isMemRead", isMemRead, e_isread);
            chk("memAddr", memAddr, e_addr);
            if (!e_isread) chk("memWriteData", memWriteData, e_wdata);
        end
    endtask

    // drives inputs for edge n+1
    task automatic drive();
        if (auto_req) begin
            for (int p = 0; p < 2; p++) begin
                if (e_ack[p]) r[p] = ($urandom_range(0, 3) == 0);
                else if (!r[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r[p] = 1; rdf[p] = 1'($urandom_range(0, 1));
                        ad[p] = AW'($urandom); wd[p] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if (busy && w == p && n >= E) begin
                    if ($urandom_range(0, 9) == 0) r[p] = 0;
                    if ($urandom_range(0, 3) == 0) begin
                        rdf[p] = 1'($urandom_range(0, 1)); ad[p] = AW'($urandom);
                        wd[p] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
            end
        end
        memReady = 0;
        memReadData = {$urandom, $urandom, $urandom, $urandom};
        if (busy && ok && n + 1 == R) begin
            memReady = 1;
            memReadData = m_data;
        end else if (auto_req && (!busy || n + 1 == E + 1 || n + 1 == R + 1) && $urandom_range(0, 7) == 0)
            memReady = 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        drive();
    endtask

    localparam logic [BW-1:0] RD_BLK = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [BW-1:0] WR_BLK = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    initial begin
        int order[$];
        int cnt, got;
        r = '{0, 0}; rdf = '{1, 1}; ad = '{'0, '0}; wd = '{'0, '0};
        memReady = 0; memReadData = '0; auto_req = 0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_isMemRead", isMemRead, 1);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_readData", readData, 0);
        rst_n = 1'b1;
        cycle();

        // contention: both held for four transactions
        r = '{1, 1}; ad = '{10'h100, 10'h200};
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            cycle();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if (order.size() >= 4) r = '{0, 0};
        end
        chk("contention_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("grant_order", order[i], EXP_ORDER[i]);
        repeat (3) cycle();

        // single read, memory answers on the second wait cycle
        ad[0] = 10'h2A4; rdf[0] = 1; force_k = 2; force_data = RD_BLK; force_data_en = 1; r[0] = 1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            cycle();
            if (memReq) begin
                chk("t2_memAddr", memAddr, 10'h2A0);
                chk("t2_isMemRead", isMemRead, 1);
            end
            if (ack0) begin
                got = 1; r[0] = 0;
                chk("t2_readData", readData, RD_BLK);
                chk("t2_ack1", ack1, 0);
                chk("t2_latency", c, 4);
            end
        end
        chk("t2_ack_seen", got, 1);
        repeat (2) cycle();

        // write on port 1, fastest response
        rdf[1] = 0; wd[1] = WR_BLK; ad[1] = 10'h3FF; force_k = 1; r[1] = 1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            cycle();
            if (memReq) begin
                chk("t4_memWriteData", memWriteData, WR_BLK);
                chk("t4_isMemRead", isMemRead, 0);
            end
            if (ack1) begin
                got = 1; r[1] = 0;
                chk("t4_readData_kept", readData, RD_BLK);
                chk("t4_latency", c, 3);
            end
        end
        chk("t4_ack_seen", got, 1);
        repeat (2) cycle();

        // timeout: memory never answers
        rdf[0] = 1; ad[0] = 10'h050; force_k = 1000; r[0] = 1;
        got = 0; cnt = 0;
        for (int c = 0; c < 80 && !got; c++) begin
            cycle();
            if (memReq) cnt++;
            if (ack0) begin
                got = 1; r[0] = 0;
                chk("t5_err0", err0, 1);
                chk("t5_readData", readData, 0);
            end
        end
        chk("t5_ack_seen", got, 1);
        chk("t5_memReq_cycles", cnt, TO + 1);
        repeat (2) cycle();

        // request dropped mid-wait still completes exactly once
        rdf[0] = 1; ad[0] = 10'h123; force_k = 4; r[0] = 1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (busy && n >= E + 2) r[0] = 0;
            if (ack0) cnt++;
        end
        chk("t6_ack_count", cnt, 1);

        // randomized traffic
        auto_req = 1;
        repeat (3000) cycle();
        auto_req = 0;
        r = '{0, 0};
        for (int c = 0; c < 100 && busy; c++) cycle();
        chk("drain_idle", busy, 0);
        repeat (3) cycle();

        // reset in the middle of a wait
        rdf[0] = 1; ad[0] = 10'h0F0; force_k = 10; r[0] = 1;
        for (int c = 0; c < 20 && !(busy && n >= E + 3); c++) cycle();
        r[0] = 0;
        chk("t1_memReq_before", memReq, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_memReq", memReq, 0);
        chk("t1_ack0", ack0, 0);
        chk("t1_ack1", ack1, 0);
        chk("t1_readData", readData, 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            cycle();
            if (ack0 || ack1) cnt++;
        end
        chk("t1_no_late_ack", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
